// File: rtl/host_spi_sample_slave.sv
// rtl/host_spi_sample_slave.sv - SPI mode-0 slave: one status byte plus one I/Q pair per chip-select frame,
// all in master_clk with oversampled SPI pins.
module host_spi_sample_slave #(
  parameter int SAMPLE_WIDTH = 12,
  parameter int LEVEL_WIDTH  = 5
) (
  input  logic                    master_clk,
  input  logic                    reset,
  input  logic                    spi_clk,
  input  logic                    spi_cs_n,
  input  logic                    spi_simo,
  output logic                    spi_somi,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [SAMPLE_WIDTH-1:0] s_i,
  input  logic [SAMPLE_WIDTH-1:0] s_q,
  input  logic [LEVEL_WIDTH-1:0]  fifo_level,
  input  logic                    rx_overrun,
  output logic [7:0]              cmd_data,
  output logic                    cmd_strobe,
  output logic                    underrun,
  output logic                    busy
);

  localparam int FRAME_BITS = 8 + 2 * SAMPLE_WIDTH;
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, DONE, WAIT_CS} state_t;

  // [1] is the synchronized pin, [2] the history bit used for edge detection
  logic [2:0] sclk_sync_q, sclk_sync_d;
  logic [2:0] cs_sync_q, cs_sync_d;
  logic [1:0] simo_sync_q, simo_sync_d;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [FRAME_BITS-1:0]   shift_q, shift_d;
  logic [7:0]              cmd_sr_q, cmd_sr_d;
  logic                    byte_done_q, byte_done_d;
  logic                    somi_q, somi_d;
  logic [7:0]              cmd_data_q, cmd_data_d;
  logic                    cmd_strobe_q, cmd_strobe_d;
  logic                    underrun_q, underrun_d;
  logic                    busy_q, busy_d;

  logic [4:0] level5;
  logic       sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic       underrun_set;

  if (LEVEL_WIDTH >= 5) begin : g_level_trunc
    assign level5 = fifo_level[4:0];
  end else begin : g_level_pad
    assign level5 = {{(5 - LEVEL_WIDTH){1'b0}}, fifo_level};
  end

  assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign cs_fall   = ~cs_sync_q[1] & cs_sync_q[2];
  assign cs_rise   = cs_sync_q[1] & ~cs_sync_q[2];

  always_comb begin
    sclk_sync_d  = {sclk_sync_q[1:0], spi_clk};
    cs_sync_d    = {cs_sync_q[1:0], spi_cs_n};
    simo_sync_d  = {simo_sync_q[0], spi_simo};
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    cmd_sr_d     = cmd_sr_q;
    byte_done_d  = 1'b0;
    somi_d       = somi_q;
    cmd_data_d   = cmd_data_q;
    cmd_strobe_d = 1'b0;
    underrun_d   = underrun_q;
    underrun_set = 1'b0;

    case (state_q)
      IDLE: begin
        somi_d = 1'b0;
        if (cs_fall) state_d = LOAD;
      end
      LOAD: begin
        // status reports the underrun flag as it stood before this frame
        shift_d = {s_valid, rx_overrun, underrun_q, level5,
                   s_valid ? {s_i, s_q} : {(2 * SAMPLE_WIDTH){1'b0}}};
        somi_d  = s_valid;
        cnt_d   = '0;
        underrun_set = ~s_valid;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (sclk_rise) begin
          cmd_sr_d = {cmd_sr_q[6:0], simo_sync_q[1]};
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(7)) byte_done_d = 1'b1;
          if (cnt_q == CNT_W'(FRAME_BITS - 1)) state_d = DONE;
        end else if (sclk_fall && cnt_q < CNT_W'(FRAME_BITS)) begin
          shift_d = shift_q << 1;
          somi_d  = shift_q[FRAME_BITS-2];
        end
      end
      DONE: begin
        if (sclk_fall) somi_d = 1'b0;
      end
      WAIT_CS: begin
        somi_d = 1'b0;
        if (cs_rise) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (cs_rise && (state_q == LOAD || state_q == SHIFT || state_q == DONE)) begin
      state_d = IDLE;
      somi_d  = 1'b0;
    end

    if (byte_done_q) begin
      cmd_data_d   = cmd_sr_q;
      cmd_strobe_d = 1'b1;
      if (cmd_sr_q[0]) underrun_d = 1'b0;
    end
    if (underrun_set) underrun_d = 1'b1;

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge master_clk) begin
    sclk_sync_q <= sclk_sync_d;
    cs_sync_q   <= cs_sync_d;
    simo_sync_q <= simo_sync_d;
    if (reset) begin
      // a frame already in progress is sat out rather than joined midway
      state_q      <= cs_sync_q[1] ? IDLE : WAIT_CS;
      cnt_q        <= '0;
      shift_q      <= '0;
      cmd_sr_q     <= '0;
      byte_done_q  <= 1'b0;
      somi_q       <= 1'b0;
      cmd_data_q   <= '0;
      cmd_strobe_q <= 1'b0;
      underrun_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      cmd_sr_q     <= cmd_sr_d;
      byte_done_q  <= byte_done_d;
      somi_q       <= somi_d;
      cmd_data_q   <= cmd_data_d;
      cmd_strobe_q <= cmd_strobe_d;
      underrun_q   <= underrun_d;
      busy_q       <= busy_d;
    end
  end

  assign s_ready    = (state_q == LOAD) && s_valid;
  assign spi_somi   = somi_q;
  assign cmd_data   = cmd_data_q;
  assign cmd_strobe = cmd_strobe_q;
  assign underrun   = underrun_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_host_spi_sample_slave.sv
// tb/tb_host_spi_sample_slave.sv - scoreboard bench acting as SPI host and as the upstream sample buffer
module tb_host_spi_sample_slave;

  localparam int SW = 12;
  localparam int LW = 5;

  logic          master_clk = 1'b0;
  logic          reset      = 1'b1;
  logic          spi_clk    = 1'b0;
  logic          spi_cs_n   = 1'b1;
  logic          spi_simo   = 1'b0;
  logic          spi_somi;
  logic          s_valid    = 1'b0;
  logic          s_ready;
  logic [SW-1:0] s_i        = '0;
  logic [SW-1:0] s_q        = '0;
  logic [LW-1:0] fifo_level = '0;
  logic          rx_overrun = 1'b0;
  logic [7:0]    cmd_data;
  logic          cmd_strobe;
  logic          underrun;
  logic          busy;

  int n_checks = 0;
  int n_pass   = 0;
  int pops     = 0;

  logic [2*SW-1:0] bfifo[$];
  logic [31:0]     exp_word[$];
  logic [7:0]      exp_cmd[$];

  host_spi_sample_slave #(.SAMPLE_WIDTH(SW), .LEVEL_WIDTH(LW)) dut (
    .master_clk (master_clk),
    .reset      (reset),
    .spi_clk    (spi_clk),
    .spi_cs_n   (spi_cs_n),
    .spi_simo   (spi_simo),
    .spi_somi   (spi_somi),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_i        (s_i),
    .s_q        (s_q),
    .fifo_level (fifo_level),
    .rx_overrun (rx_overrun),
    .cmd_data   (cmd_data),
    .cmd_strobe (cmd_strobe),
    .underrun   (underrun),
    .busy       (busy)
  );

  always #5 master_clk = ~master_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] mk_word(input logic v, input logic o, input logic u,
                                          input logic [4:0] lvl, input logic [SW-1:0] i,
                                          input logic [SW-1:0] q);
    return {v, o, u, lvl, v ? {i, q} : 24'h0};
  endfunction

  // Upstream buffer: head presented on s_i/s_q, popped once the pop cycle has passed
  initial begin
    forever begin
      @(negedge master_clk);
      if (s_ready) begin
        pops++;
        @(posedge master_clk);
        #1;
        if (bfifo.size() > 0) void'(bfifo.pop_front());
      end
      s_valid = (bfifo.size() > 0);
      if (bfifo.size() > 0) {s_i, s_q} = bfifo[0];
    end
  end

  initial begin
    forever begin
      @(negedge master_clk);
      if (cmd_strobe) begin
        check("strobe_expected", 64'(exp_cmd.size() > 0), 64'd1);
        if (exp_cmd.size() > 0) check("cmd_data", cmd_data, exp_cmd.pop_front());
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic sclk_cycle(input logic simo, output logic sampled);
    spi_simo = simo;
    repeat (5) @(negedge master_clk);
    spi_clk = 1'b1;
    sampled = spi_somi;
    repeat (5) @(negedge master_clk);
    spi_clk = 1'b0;
  endtask

  task automatic spi_xfer(input int nclk, input logic [7:0] cmd, output logic [63:0] rx);
    logic b;
    rx = '0;
    spi_cs_n = 1'b0;
    repeat (8) @(negedge master_clk);
    for (int k = 0; k < nclk; k++) begin
      sclk_cycle((k < 8) ? cmd[7-k] : 1'b0, b);
      rx = {rx[62:0], b};
    end
    spi_simo = 1'b0;
    repeat (5) @(negedge master_clk);
    spi_cs_n = 1'b1;
    repeat (6) @(negedge master_clk);
  endtask

  task automatic run_frame(input int nclk, input logic [7:0] cmd, input logic [31:0] exp);
    logic [63:0] rx;
    logic [63:0] mask;
    exp_word.push_back(exp);
    if (nclk >= 8) exp_cmd.push_back(cmd);
    spi_xfer(nclk, cmd, rx);
    check("frame_word", 64'(32'(rx >> (nclk - 32))), 64'(exp_word.pop_front()));
    if (nclk > 32) begin
      mask = (64'd1 << (nclk - 32)) - 64'd1;
      check("frame_tail", rx & mask, 64'd0);
    end
    check("cmd_pending", 64'(exp_cmd.size()), 64'd0);
  endtask

  task automatic load_buf(input logic [SW-1:0] i, input logic [SW-1:0] q);
    bfifo.push_back({i, q});
    repeat (2) @(negedge master_clk);
  endtask

  initial begin
    int p0;
    logic b;
    logic somi_or;

    repeat (5) @(negedge master_clk);
    check("rst_somi", spi_somi, 0);
    check("rst_s_ready", s_ready, 0);
    check("rst_cmd_data", cmd_data, 0);
    check("rst_cmd_strobe", cmd_strobe, 0);
    check("rst_underrun", underrun, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    repeat (4) @(negedge master_clk);
    check("idle_busy", busy, 0);

    // frame with data
    fifo_level = 5'd3;
    load_buf(12'hABC, 12'h123);
    p0 = pops;
    run_frame(32, 8'h00, 32'h83ABC123);
    check("data_pops", 64'(pops - p0), 1);

    // underrun: empty buffer
    fifo_level = 5'd0;
    p0 = pops;
    run_frame(32, 8'h00, 32'h00000000);
    check("und_pops", 64'(pops - p0), 0);
    check("und_set", underrun, 1);

    // underrun shown in status, then cleared by command bit 0
    load_buf(12'h001, 12'h002);
    p0 = pops;
    run_frame(32, 8'h01, 32'hA0001002);
    check("clr_pops", 64'(pops - p0), 1);
    check("und_clear", underrun, 0);

    // abort after 5 clocks
    fifo_level = 5'd2;
    load_buf(12'h111, 12'h222);
    load_buf(12'h333, 12'h444);
    p0 = pops;
    begin
      logic [63:0] rx;
      spi_xfer(5, 8'hFF, rx);
    end
    check("abort_busy", busy, 0);
    check("abort_somi", spi_somi, 0);
    check("abort_pops", 64'(pops - p0), 1);
    fifo_level = 5'd1;
    run_frame(32, 8'h3C, mk_word(1'b1, 1'b0, 1'b0, 5'd1, 12'h333, 12'h444));

    // long frame
    load_buf(12'h555, 12'h666);
    p0 = pops;
    run_frame(40, 8'h5A, mk_word(1'b1, 1'b0, 1'b0, 5'd1, 12'h555, 12'h666));
    check("long_pops", 64'(pops - p0), 1);

    // reset mid-frame with CS held low
    fifo_level = 5'd2;
    load_buf(12'h777, 12'h888);
    load_buf(12'h999, 12'hAAA);
    p0 = pops;
    exp_cmd.push_back(8'h00);
    spi_cs_n = 1'b0;
    repeat (8) @(negedge master_clk);
    for (int k = 0; k < 12; k++) sclk_cycle(1'b0, b);
    reset = 1'b1;
    repeat (3) @(negedge master_clk);
    reset = 1'b0;
    repeat (3) @(negedge master_clk);
    check("wait_cs_busy", busy, 1);
    somi_or = 1'b0;
    for (int k = 0; k < 20; k++) begin
      sclk_cycle(1'b1, b);
      somi_or = somi_or | b | spi_somi;
    end
    check("wait_cs_somi", somi_or, 0);
    check("wait_cs_cmd", 64'(exp_cmd.size()), 0);
    spi_cs_n = 1'b1;
    repeat (6) @(negedge master_clk);
    check("post_rst_busy", busy, 0);
    check("rst_frame_pops", 64'(pops - p0), 1);
    fifo_level = 5'd1;
    run_frame(32, 8'h00, mk_word(1'b1, 1'b0, 1'b0, 5'd1, 12'h999, 12'hAAA));

    // overrun passthrough and full level
    rx_overrun = 1'b1;
    fifo_level = 5'd31;
    load_buf(12'hFFF, 12'hFFF);
    run_frame(32, 8'h00, 32'hDFFFFFFF);
    rx_overrun = 1'b0;

    repeat (10) @(negedge master_clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
